load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 35 +++
 rtl/load_store_unit.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the RV32I load/store unit.
// Contents: FSM state enum, RV32I load/store funct3 codes, and extend(),
// which sign/zero-extends a right-aligned byte or halfword according to the
// load funct3 (LW and anything else pass through unchanged).
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  function automatic logic [31:0] extend(input logic [31:0] data, input logic [2:0] funct3);
    logic [31:0] res;
    case (funct3)
      F3_LB:   res = {{24{data[7]}}, data[7:0]};
      F3_LH:   res = {{16{data[15]}}, data[15:0]};
      F3_LBU:  res = {24'd0, data[7:0]};
      F3_LHU:  res = {16'd0, data[15:0]};
      default: res = data;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/load_store_unit.sv
// RV32I load/store unit between a core request port and a single-ported
// byte-addressed memory with one-cycle read latency.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   req_valid/req_ready            request handshake (ready only in IDLE)
//   req_write, req_funct3,
//   req_addr, req_wdata            access description, captured on accept
//   rsp_valid, rsp_rdata, rsp_err  one-cycle completion pulse and result
//   mem_write, mem_funct3,
//   mem_write_address/_data,
//   mem_read_address/_data         memory side
// Misaligned words and halves are broken into byte accesses; the loaded
// bytes are reassembled little-endian and extended at the end.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_write,
  output logic [2:0]  mem_funct3,
  output logic [31:0] mem_write_address,
  output logic [31:0] mem_write_data,
  output logic [31:0] mem_read_address,
  input  logic [31:0] mem_read_data
);

  lsu_state_e  r_state;
  lsu_state_e  w_state_next;
  logic        r_write;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_cnt;
  logic [31:0] r_rdata;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;

  logic        w_illegal;
  logic        w_split;
  logic [1:0]  w_last_cnt;
  logic        w_last;
  logic [31:0] w_mem_addr;
  logic [31:0] w_assembled;
  logic [4:0]  w_byte_base;

  // Illegal encodings are judged on the live request so an error can skip ISSUE.
  assign w_illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                     (req_funct3 == 3'b111) || (req_write && req_funct3[2]);

  assign w_split = ((r_funct3[1:0] == 2'b10) && (r_addr[1:0] != 2'b00)) ||
                   ((r_funct3[1:0] == 2'b01) && r_addr[0]);

  // Words split into 4 bytes, halves into 2.
  assign w_last_cnt  = r_funct3[1] ? 2'd3 : 2'd1;
  assign w_last      = !w_split || (r_cnt == w_last_cnt);
  assign w_byte_base = {r_cnt, 3'b000};
  // The counter only advances on leaving WAIT (loads), so the address is
  // stable across the ISSUE/WAIT pair of each byte.
  assign w_mem_addr  = w_split ? (r_addr + {30'd0, r_cnt}) : r_addr;

  always_comb begin
    w_assembled = mem_read_data;
    if (w_split) begin
      w_assembled = r_rdata;
      w_assembled[w_byte_base +: 8] = mem_read_data[7:0];
    end
  end

  assign mem_funct3        = w_split ? (r_write ? F3_SB : F3_LBU) : r_funct3;
  assign mem_write_address = w_mem_addr;
  assign mem_read_address  = w_mem_addr;
  assign mem_write_data    = w_split ? {24'd0, r_wdata[w_byte_base +: 8]} : r_wdata;
  assign rsp_rdata         = r_rsp_rdata;
  assign rsp_err           = r_rsp_err;

  always_comb begin
    w_state_next = r_state;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    mem_write    = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_state_next = w_illegal ? RESP : ISSUE;
      end
      ISSUE: begin
        if (r_write) begin
          mem_write    = 1'b1;
          w_state_next = w_last ? RESP : ISSUE;
        end else begin
          w_state_next = WAIT;
        end
      end
      WAIT: w_state_next = w_last ? RESP : ISSUE;
      RESP: begin
        rsp_valid    = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_write     <= 1'b0;
      r_funct3    <= 3'd0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_cnt       <= 2'd0;
      r_rdata     <= 32'd0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_write     <= req_write;
            r_funct3    <= req_funct3;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_cnt       <= 2'd0;
            r_rdata     <= 32'd0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= w_illegal;
          end
        end
        ISSUE: begin
          if (r_write && !w_last) r_cnt <= r_cnt + 2'd1;
        end
        WAIT: begin
          r_rdata <= w_assembled;
          if (w_last) r_rsp_rdata <= extend(w_assembled, r_funct3);
          else        r_cnt <= r_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
